warp_issue_unit: RTL and testbench

WARP_ISSUE_UNIT -- requirements
Module: warp_issue_unit

---
 rtl/warp_issue_unit.sv | 160 ++++++++++++++++
 tb/tb_warp_issue_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_issue_unit.sv
// Warp issue unit: fetches, decodes and broadcasts one instruction at a time to
// NUM_THREADS func_unit lanes, waiting for every active lane to complete before fetching again.
module warp_issue_unit #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    base_pc,
  input  logic [NUM_THREADS-1:0] thread_mask,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [2:0]             type_instruction,
  output logic [4:0]             regnum_1,
  output logic [4:0]             regnum_2,
  output logic [4:0]             dest_reg,
  output logic [5:0]             shammt,
  output logic [NUM_THREADS-1:0] is_active,
  output logic                   issue_valid,
  input  logic [NUM_THREADS-1:0] thread_complete,
  output logic                   busy,
  output logic                   done,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [15:0]            instr_count,
  output logic [2:0]             dbg_state
);

  // issue_valid is a one-cycle strobe with no back-pressure; lanes acknowledge
  // by pulsing or holding thread_complete, and a lane counts once it has asserted it.
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_FINISH
  } state_t;

  localparam logic [2:0] OP_HALT = 3'b111;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [15:0]            count_q, count_d;
  logic [NUM_THREADS-1:0] active_q, active_d;
  logic [NUM_THREADS-1:0] sticky_q, sticky_d;
  logic [2:0]             type_q, type_d;
  logic [4:0]             rs1_q, rs1_d, rs2_q, rs2_d, dst_q, dst_d;
  logic [5:0]             sh_q, sh_d;
  logic [NUM_THREADS-1:0] seen_done;
  logic                   rdata_unused;

  assign rdata_unused = ^imem_rdata[7:0];
  assign seen_done    = (sticky_q | thread_complete) & active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      count_q  <= '0;
      active_q <= '0;
      sticky_q <= '0;
      type_q   <= OP_HALT;
      rs1_q    <= 5'h1F;
      rs2_q    <= 5'h1F;
      dst_q    <= 5'h1F;
      sh_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      active_q <= active_d;
      sticky_q <= sticky_d;
      type_q   <= type_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      dst_q    <= dst_d;
      sh_q     <= sh_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    active_d = active_q;
    sticky_d = sticky_q;
    type_d   = type_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    dst_d    = dst_q;
    sh_d     = sh_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d     = base_pc;
          active_d = thread_mask;
          count_d  = '0;
          sticky_d = '0;
          state_d  = (thread_mask == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        type_d  = imem_rdata[31:29];
        dst_d   = imem_rdata[28:24];
        rs1_d   = imem_rdata[23:19];
        rs2_d   = imem_rdata[18:14];
        sh_d    = imem_rdata[13:8];
        state_d = (imem_rdata[31:29] == OP_HALT) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        sticky_d = sticky_q | (thread_complete & active_q);
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (seen_done == active_q) begin
          pc_d     = pc_q + PC_WIDTH'(1);
          count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          sticky_d = '0;
          state_d  = S_FETCH;
        end else begin
          sticky_d = seen_done;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Reset masks every strobe and forces the idle decode pattern combinationally.
  always_comb begin
    imem_req         = 1'b0;
    issue_valid      = 1'b0;
    done             = 1'b0;
    busy             = 1'b0;
    type_instruction = OP_HALT;
    regnum_1         = 5'h1F;
    regnum_2         = 5'h1F;
    dest_reg         = 5'h1F;
    shammt           = '0;
    is_active        = '0;
    if (!rst) begin
      busy        = (state_q != S_IDLE);
      imem_req    = (state_q == S_FETCH);
      issue_valid = (state_q == S_ISSUE);
      done        = (state_q == S_FINISH);
      if (state_q != S_IDLE && state_q != S_FINISH) begin
        type_instruction = type_q;
        regnum_1         = rs1_q;
        regnum_2         = rs2_q;
        dest_reg         = dst_q;
        shammt           = sh_q;
        is_active        = active_q;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_warp_issue_unit.sv
// Self-checking bench for warp_issue_unit: directed kernels plus random programs,
// each compared against an instruction-list/timing model derived from the behaviour rules.
module tb_warp_issue_unit;
  localparam int NT = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] base_pc = '0;
  logic [NT-1:0] thread_mask = '0;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic [2:0]    type_instruction;
  logic [4:0]    regnum_1, regnum_2, dest_reg;
  logic [5:0]    shammt;
  logic [NT-1:0] is_active;
  logic          issue_valid;
  logic [NT-1:0] thread_complete = '0;
  logic          busy, done;
  logic [PW-1:0] pc;
  logic [15:0]   instr_count;
  logic [2:0]    dbg_state;

  warp_issue_unit #(.NUM_THREADS(NT), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_pc(base_pc), .thread_mask(thread_mask),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .type_instruction(type_instruction), .regnum_1(regnum_1), .regnum_2(regnum_2),
    .dest_reg(dest_reg), .shammt(shammt), .is_active(is_active), .issue_valid(issue_valid),
    .thread_complete(thread_complete), .busy(busy), .done(done), .pc(pc),
    .instr_count(instr_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory and lane responders ----------------
  logic [31:0] mem [256];
  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

  int lane_dly [NT];
  int since_issue = 1000;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [2:0]    done_type;
  logic [NT-1:0] done_act;
  logic [23:0]   obs_q [$];
  int            obs_cyc_q [$];
  logic [NT-1:0] obs_act_q [$];
  logic [PW-1:0] obs_pc_q [$];
  logic [PW-1:0] fetch_q [$];

  always @(negedge clk) begin
    logic [NT-1:0] tc;
    if (issue_valid) begin
      obs_q.push_back({type_instruction, dest_reg, regnum_1, regnum_2, shammt});
      obs_cyc_q.push_back(cyc);
      obs_act_q.push_back(is_active);
      obs_pc_q.push_back(pc);
      since_issue = 0;
    end else if (since_issue < 1000) begin
      since_issue++;
    end
    if (imem_req) fetch_q.push_back(imem_addr);
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_type = type_instruction;
      done_act  = is_active;
    end
    for (int l = 0; l < NT; l++) tc[l] = (lane_dly[l] >= 0) && (since_issue == lane_dly[l]);
    thread_complete = tc;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] t, input logic [4:0] d,
                                     input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [5:0] sh);
    logic [7:0] junk;
    junk = 8'($urandom);
    return {t, d, r1, r2, sh, junk};
  endfunction

  function automatic logic [31:0] halt_word();
    return mk(3'b111, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
  endfunction

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    lane_dly[0] = d0; lane_dly[1] = d1; lane_dly[2] = d2; lane_dly[3] = d3;
  endtask

  // Runs one kernel and compares against a model built from the program in mem.
  task automatic run_kernel(input string tag, input logic [PW-1:0] bpc,
                            input logic [NT-1:0] mask, input bit poke);
    logic [23:0]   exp_q [$];
    logic [PW-1:0] exp_pc_q [$];
    logic [PW-1:0] exp_fetch_q [$];
    logic [PW-1:0] addr;
    int w, s, t, d0, n, exp_done;
    if (busy) begin
      rst = 1'b1; step(); rst = 1'b0; step();
    end
    addr = bpc;
    while (mem[addr][31:29] != 3'b111 && exp_q.size() < 64) begin
      exp_q.push_back(mem[addr][31:8]);
      exp_pc_q.push_back(addr);
      exp_fetch_q.push_back(addr);
      addr = addr + 8'd1;
    end
    exp_fetch_q.push_back(addr);
    if (mask == '0) begin
      exp_q.delete(); exp_pc_q.delete(); exp_fetch_q.delete();
      addr = bpc;
    end
    w = 1;
    for (int l = 0; l < NT; l++) if (mask[l] && lane_dly[l] > w) w = lane_dly[l];
    obs_q.delete(); obs_cyc_q.delete(); obs_act_q.delete(); obs_pc_q.delete(); fetch_q.delete();
    d0 = done_cnt;
    start = 1'b1; base_pc = bpc; thread_mask = mask; s = cyc;
    step();
    start = 1'b0; base_pc = 8'($urandom); thread_mask = 4'($urandom);
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      if (poke && obs_q.size() == 1 && cyc == obs_cyc_q[0] + 2) start = 1'b1;
      else start = 1'b0;
      step();
      t++;
    end
    start = 1'b0;
    check({tag, " done_in_time"}, 32'(t < 3000), 32'd1);
    check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
    if (exp_q.size() == 0) exp_done = (mask == '0) ? s + 1 : s + 3;
    else exp_done = obs_cyc_q.size() > 0 ? obs_cyc_q[obs_cyc_q.size()-1] + w + 3 : -1;
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({tag, " done_type"}, 32'(done_type), 32'd7);
    check({tag, " done_active"}, 32'(done_act), 32'd0);
    check({tag, " issue_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s issue%0d_fields", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      check($sformatf("%s issue%0d_pc", tag, i), 32'(obs_pc_q[i]), 32'(exp_pc_q[i]));
      check($sformatf("%s issue%0d_active", tag, i), 32'(obs_act_q[i]), 32'(mask));
      if (i == 0) check($sformatf("%s issue0_latency", tag), 32'(obs_cyc_q[0] - s), 32'd3);
      else check($sformatf("%s issue%0d_spacing", tag, i),
                 32'(obs_cyc_q[i] - obs_cyc_q[i-1]), 32'(w + 3));
    end
    check({tag, " fetch_count"}, 32'(fetch_q.size()), 32'(exp_fetch_q.size()));
    n = (fetch_q.size() < exp_fetch_q.size()) ? fetch_q.size() : exp_fetch_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s fetch%0d_addr", tag, i), 32'(fetch_q[i]), 32'(exp_fetch_q[i]));
    check({tag, " instr_count"}, 32'(instr_count), 32'(exp_q.size()));
    check({tag, " final_pc"}, 32'(pc), 32'(addr));
    step();
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int d0, t;
    logic [PW-1:0] a, b;
    logic [NT-1:0] m;
    for (int i = 0; i < 256; i++) mem[i] = halt_word();
    set_dly(2, 2, 2, 2);

    // reset state
    rst = 1'b1; start = 1'b1; thread_mask = 4'hF;
    step(); step();
    check("rst busy", 32'(busy), 32'd0);
    check("rst imem_req", 32'(imem_req), 32'd0);
    check("rst issue_valid", 32'(issue_valid), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst is_active", 32'(is_active), 32'd0);
    check("rst decode", 32'({type_instruction, dest_reg, regnum_1, regnum_2, shammt}),
          32'({3'b111, 5'h1F, 5'h1F, 5'h1F, 6'h0}));
    rst = 1'b0; start = 1'b0; thread_mask = '0;
    step();
    check("rst pc", 32'(pc), 32'd0);
    check("rst instr_count", 32'(instr_count), 32'd0);
    check("rst idle", 32'(busy), 32'd0);

    // LOAD + compute + HALT, all lanes complete two cycles after issue
    mem[8'h10] = mk(3'b110, 5'd2, 5'd0, 5'd0, 6'd0);
    mem[8'h11] = mk(3'b000, 5'd3, 5'd1, 5'd9, 6'd0);
    mem[8'h12] = halt_word();
    run_kernel("basic", 8'h10, 4'b1111, 1'b0);

    // sparse mask, staggered lanes, stray inactive completion on lane 1
    mem[8'h20] = mk(3'b001, 5'd4, 5'd5, 5'd6, 6'd7);
    mem[8'h21] = mk(3'b010, 5'd8, 5'd9, 5'd10, 6'd11);
    mem[8'h22] = halt_word();
    set_dly(1, 2, 4, -1);
    run_kernel("stagger", 8'h20, 4'b0101, 1'b0);

    // empty mask: immediate finish, no fetch
    run_kernel("nomask", 8'h55, 4'b0000, 1'b0);

    // pc wrap from 0xFF to 0x00
    mem[8'hFF] = mk(3'b101, 5'd17, 5'd30, 5'd2, 6'h2A);
    mem[8'h00] = halt_word();
    set_dly(1, 3, 2, 0);
    run_kernel("wrap", 8'hFF, 4'b1111, 1'b0);

    // HALT as the first instruction
    mem[8'h40] = halt_word();
    set_dly(1, 1, 1, 1);
    run_kernel("halt_first", 8'h40, 4'b0011, 1'b0);

    // reset in WAIT aborts without done, then a normal kernel runs
    set_dly(20, 20, 20, 20);
    d0 = done_cnt; obs_q.delete();
    start = 1'b1; base_pc = 8'h10; thread_mask = 4'b1111;
    step(); start = 1'b0;
    t = 0;
    while (obs_q.size() == 0 && t < 50) begin step(); t++; end
    check("rstwait reached_issue", 32'(t < 50), 32'd1);
    step();
    rst = 1'b1;
    step();
    check("rstwait busy", 32'(busy), 32'd0);
    check("rstwait is_active", 32'(is_active), 32'd0);
    rst = 1'b0;
    step();
    check("rstwait pc", 32'(pc), 32'd0);
    check("rstwait instr_count", 32'(instr_count), 32'd0);
    check("rstwait still_idle", 32'(busy), 32'd0);
    repeat (25) step();
    check("rstwait no_done", 32'(done_cnt - d0), 32'd0);
    set_dly(2, 2, 2, 2);
    run_kernel("after_rst", 8'h10, 4'b1111, 1'b0);

    // start pulsed during WAIT is ignored
    mem[8'h30] = mk(3'b011, 5'd1, 5'd2, 5'd3, 6'd4);
    mem[8'h31] = mk(3'b100, 5'd5, 5'd6, 5'd7, 6'd8);
    mem[8'h32] = halt_word();
    set_dly(5, 5, 5, 5);
    run_kernel("start_in_wait", 8'h30, 4'b1011, 1'b1);

    // random programs, masks and completion delays
    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom_range(0, 255));
      t = $urandom_range(1, 4);
      for (int i = 0; i < t; i++) begin
        b = a + 8'(i);
        mem[b] = mk(3'($urandom_range(0, 6)), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
      end
      b = a + 8'(t);
      mem[b] = halt_word();
      m = 4'($urandom_range(1, 15));
      for (int l = 0; l < NT; l++) lane_dly[l] = $urandom_range(0, 5);
      run_kernel($sformatf("rand%0d", k), a, m, 1'($urandom_range(0, 1)) && lane_dly[0] >= 3
                 && lane_dly[1] >= 3 && lane_dly[2] >= 3 && lane_dly[3] >= 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
